frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter COORD_W, default 13, meaning width of image dimensions and pixel coordinates.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the completed-frame counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; frames run back-to-back while high.
REQ-006 SHALL have port cfg_update  input  1  single-cycle strobe; captures cfg_* into shadow registers.
REQ-007 SHALL have port cfg_width, cfg_height  input  COORD_W  requested image size in pixels.
REQ-008 SHALL have port cfg_cam_pos, cfg_cam_dir  input  33  packed {z,y,x} 11-bit camera position and direction.
REQ-009 SHALL have port cfg_distance  input  32  requested camera-to-screen distance.
REQ-010 SHALL have port px_ready  input  1  downstream ray generator accepts the current coordinate.
REQ-011 SHALL have port px_valid  output  1  px_x/px_y/flags hold a valid coordinate.
REQ-012 SHALL have port px_x, px_y  output  COORD_W  current pixel coordinate.
REQ-013 SHALL have port px_sof, px_eol, px_eof  output  1  first pixel of frame / last pixel of row / last pixel of frame.
REQ-014 SHALL have port act_width, act_height, act_cam_pos, act_cam_dir, act_distance  output  as cfg_*  configuration applied to the current frame.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port cfg_err  output  1  sticky; a frame start was refused due to zero width or height.
REQ-017 SHALL have port frame_count  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-019 IDLE->LOAD when enable=1; otherwise stay in IDLE.
REQ-020 LOAD (exactly 1 cycle): copy shadow to act_*; if shadow width or height is 0, set cfg_err and go to IDLE, else set x=y=0 and go to RUN.
REQ-021 RUN: px_valid=1; a transfer occurs on a cycle with px_valid=1 and px_ready=1.
REQ-022 While px_valid=1 and px_ready=0, px_x, px_y and flags SHALL hold stable.
REQ-023 On transfer: if x<W-1 then x+1; else x=0 and y+1; at x=W-1 and y=H-1 go to DONE.
REQ-024 px_sof=1 iff (x,y)=(0,0); px_eol=1 iff x=W-1; px_eof=1 iff x=W-1 and y=H-1; all flags qualified by px_valid.
REQ-025 DONE (exactly 1 cycle): px_valid=0, frame_count+1; go to LOAD if enable=1, else to IDLE.
REQ-026 Latency: enable sampled high in IDLE -> px_valid=1 with (0,0) on the 2nd following edge.
REQ-027 Deasserting enable mid-frame SHALL NOT abort; the frame completes, then returns to IDLE.
REQ-028 cfg_update SHALL load the shadow in any state; act_* change only in LOAD, never mid-frame.
REQ-029 cfg_update in the same cycle as LOAD SHALL apply the previous shadow; the new value takes effect at the next LOAD.
REQ-030 W=1 SHALL assert px_eol on every pixel; W=H=1 SHALL assert px_sof, px_eol and px_eof together.
REQ-031 Coordinate arithmetic SHALL be unsigned COORD_W bits; W-1 and H-1 are computed from act_* only.

Reset
REQ-032 On reset_n=0: state IDLE, px_valid=0, px_x=px_y=0, all flags 0, busy=0, cfg_err=0, frame_count=0.
REQ-033 On reset_n=0: shadow and act_* SHALL be 0 (width=height=0), so cfg_update is required before a valid frame.
REQ-034 Reset asserted mid-frame SHALL force reset values immediately, without waiting for a clock edge.

Verification
REQ-035 cfg 4x2, enable held high, px_ready=1 -> 8 transfers, sof at (0,0), eol at x=3, eof at (3,1), frame_count=1, LOAD 1 cycle later.
REQ-036 cfg 3x3, px_ready toggled pseudo-randomly -> coordinates stable while stalled, exactly 9 transfers in raster order.
REQ-037 cfg 8x8 running; cfg_update with 2x2 at pixel (3,2) -> act_width stays 8 until DONE; next frame is 2x2.
REQ-038 reset only, then enable=1 with no cfg_update -> LOAD, cfg_err=1, back to IDLE, px_valid never 1.
REQ-039 cfg 1x1, enable pulsed for one cycle -> single pixel with sof/eol/eof=1, frame_count=1, IDLE, busy=0.
REQ-040 reset_n dropped at pixel (2,1) of 4x4 -> px_valid=0 and frame_count=0 asynchronously; restart begins at (0,0).

Source files
------------

// File: rtl/frame_scheduler.sv
// Frame scheduler: walks a raster of pixel coordinates for each frame and
// hands them to a downstream ray generator over a valid/ready handshake.
// Configuration is captured into shadow registers at any time and applied
// to the active set only at frame start, so a frame never sees a mid-frame
// configuration change.
module frame_scheduler #(
  parameter int COORD_W = 13,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_update,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [32:0]        cfg_cam_pos,
  input  logic [32:0]        cfg_cam_dir,
  input  logic [31:0]        cfg_distance,
  input  logic               px_ready,
  output logic               px_valid,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_sof,
  output logic               px_eol,
  output logic               px_eof,
  output logic [COORD_W-1:0] act_width,
  output logic [COORD_W-1:0] act_height,
  output logic [32:0]        act_cam_pos,
  output logic [32:0]        act_cam_dir,
  output logic [31:0]        act_distance,
  output logic               busy,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  logic [COORD_W-1:0] sh_width;
  logic [COORD_W-1:0] sh_height;
  logic [32:0]        sh_cam_pos;
  logic [32:0]        sh_cam_dir;
  logic [31:0]        sh_distance;

  // Last-column / last-row limits come from the active configuration only.
  logic [COORD_W-1:0] w_max;
  logic [COORD_W-1:0] h_max;
  logic [COORD_W-1:0] x_inc;
  logic [COORD_W-1:0] y_inc;
  logic               transfer;

  assign w_max    = act_width - COORD_W'(1);
  assign h_max    = act_height - COORD_W'(1);
  assign x_inc    = px_x + COORD_W'(1);
  assign y_inc    = px_y + COORD_W'(1);
  assign transfer = px_valid & px_ready;

  // Shadow configuration capture; allowed in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_width    <= '0;
      sh_height   <= '0;
      sh_cam_pos  <= '0;
      sh_cam_dir  <= '0;
      sh_distance <= '0;
    end else if (cfg_update) begin
      sh_width    <= cfg_width;
      sh_height   <= cfg_height;
      sh_cam_pos  <= cfg_cam_pos;
      sh_cam_dir  <= cfg_cam_dir;
      sh_distance <= cfg_distance;
    end
  end

  // Frame sequencing FSM with registered coordinate, flag and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      px_valid     <= 1'b0;
      px_x         <= '0;
      px_y         <= '0;
      px_sof       <= 1'b0;
      px_eol       <= 1'b0;
      px_eof       <= 1'b0;
      act_width    <= '0;
      act_height   <= '0;
      act_cam_pos  <= '0;
      act_cam_dir  <= '0;
      act_distance <= '0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      frame_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          // A cfg_update landing in this cycle only reaches the shadow, so the
          // previous shadow contents are what get applied here.
          act_width    <= sh_width;
          act_height   <= sh_height;
          act_cam_pos  <= sh_cam_pos;
          act_cam_dir  <= sh_cam_dir;
          act_distance <= sh_distance;
          if ((sh_width == '0) || (sh_height == '0)) begin
            cfg_err <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            // First pixel flags are derived from the size being loaded.
            px_x     <= '0;
            px_y     <= '0;
            px_valid <= 1'b1;
            px_sof   <= 1'b1;
            px_eol   <= (sh_width == COORD_W'(1));
            px_eof   <= (sh_width == COORD_W'(1)) && (sh_height == COORD_W'(1));
            state    <= RUN;
          end
        end

        RUN: begin
          if (transfer) begin
            px_sof <= 1'b0;
            if (px_x == w_max) begin
              if (px_y == h_max) begin
                px_valid <= 1'b0;
                px_eol   <= 1'b0;
                px_eof   <= 1'b0;
                state    <= DONE;
              end else begin
                px_x   <= '0;
                px_y   <= y_inc;
                px_eol <= (w_max == '0);
                px_eof <= (w_max == '0) && (y_inc == h_max);
              end
            end else begin
              px_x   <= x_inc;
              px_eol <= (x_inc == w_max);
              px_eof <= (x_inc == w_max) && (px_y == h_max);
            end
          end
        end

        DONE: begin
          frame_count <= frame_count + CNT_W'(1);
          if (enable) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          px_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus pushes the expected raster
// into a queue, a negedge monitor pops and compares on every transfer and
// also checks that a stalled coordinate holds steady.
module tb_frame_scheduler;

  localparam int COORD_W = 13;
  localparam int CNT_W   = 16;

  logic               clk;
  logic               reset_n;
  logic               enable;
  logic               cfg_update;
  logic [COORD_W-1:0] cfg_width;
  logic [COORD_W-1:0] cfg_height;
  logic [32:0]        cfg_cam_pos;
  logic [32:0]        cfg_cam_dir;
  logic [31:0]        cfg_distance;
  logic               px_ready;
  logic               px_valid;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               px_sof;
  logic               px_eol;
  logic               px_eof;
  logic [COORD_W-1:0] act_width;
  logic [COORD_W-1:0] act_height;
  logic [32:0]        act_cam_pos;
  logic [32:0]        act_cam_dir;
  logic [31:0]        act_distance;
  logic               busy;
  logic               cfg_err;
  logic [CNT_W-1:0]   frame_count;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
    logic               eof;
  } px_t;

  px_t sb[$];
  int  checks = 0;
  int  errors = 0;

  frame_scheduler #(.COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_update(cfg_update),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_cam_pos(cfg_cam_pos),
    .cfg_cam_dir(cfg_cam_dir), .cfg_distance(cfg_distance), .px_ready(px_ready),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_sof(px_sof),
    .px_eol(px_eol), .px_eof(px_eof), .act_width(act_width),
    .act_height(act_height), .act_cam_pos(act_cam_pos),
    .act_cam_dir(act_cam_dir), .act_distance(act_distance), .busy(busy),
    .cfg_err(cfg_err), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int w, input int h);
    px_t p;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        p.x   = COORD_W'(xx);
        p.y   = COORD_W'(yy);
        p.sof = (xx == 0) && (yy == 0);
        p.eol = (xx == w - 1);
        p.eof = (xx == w - 1) && (yy == h - 1);
        sb.push_back(p);
      end
    end
  endtask

  // Called just after a posedge; cfg_update is high for exactly one edge.
  task automatic do_cfg(input int w, input int h);
    cfg_width    = COORD_W'(w);
    cfg_height   = COORD_W'(h);
    cfg_cam_pos  = 33'h0_1234_5678 + 33'(w);
    cfg_cam_dir  = 33'h1_0F0F_0F0F - 33'(h);
    cfg_distance = 32'd1000 + 32'(w * h);
    cfg_update   = 1'b1;
    @(posedge clk); #1;
    cfg_update   = 1'b0;
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) return;
    end
    check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Returns at the negedge where (x,y) is being transferred.
  task automatic wait_at(input string name, input int x, input int y, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (px_valid && px_ready && px_x == COORD_W'(x) && px_y == COORD_W'(y)) return;
    end
    check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Monitor: compare every transfer against the scoreboard and check stall stability.
  initial begin
    px_t got;
    px_t held;
    px_t exp;
    logic stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = '{x: px_x, y: px_y, sof: px_sof, eol: px_eol, eof: px_eof};
      if (reset_n && px_valid) begin
        if (stalled) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL stall_hold: got x=%0d y=%0d f=%b%b%b expected x=%0d y=%0d f=%b%b%b",
                     got.x, got.y, got.sof, got.eol, got.eof,
                     held.x, held.y, held.sof, held.eol, held.eof);
          end
        end
        if (px_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_px: got x=%0d y=%0d with no pixel expected", got.x, got.y);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL px: got x=%0d y=%0d sof=%b eol=%b eof=%b expected x=%0d y=%0d sof=%b eol=%b eof=%b",
                       got.x, got.y, got.sof, got.eol, got.eof,
                       exp.x, exp.y, exp.sof, exp.eol, exp.eof);
            end
          end
        end
      end
      stalled = reset_n && px_valid && !px_ready;
      held    = got;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; cfg_update = 1'b0; px_ready = 1'b1;
    cfg_width = '0; cfg_height = '0; cfg_cam_pos = '0; cfg_cam_dir = '0; cfg_distance = '0;
    #2;
    // Reset state
    check("rst_valid", 64'(px_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_act_width", 64'(act_width), 64'd0);
    check("rst_xy", 64'({px_x, px_y, px_sof, px_eol, px_eof}), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Enable without any configuration: refused frame, sticky cfg_err
    pulse_enable();
    check("nocfg_busy_load", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("nocfg_cfg_err", 64'(cfg_err), 64'd1);
    check("nocfg_busy", 64'(busy), 64'd0);
    check("nocfg_valid", 64'(px_valid), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("nocfg_err_sticky", 64'(cfg_err), 64'd1);
    reset_n = 1'b0;
    #3 check("err_cleared", 64'(cfg_err), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 4x2 back-to-back frames; enable dropped mid second frame
    do_cfg(4, 2);
    push_frame(4, 2);
    push_frame(4, 2);
    enable = 1'b1;
    wait_at("f4x2_eof", 3, 1, 40);
    @(posedge clk); @(negedge clk);
    check("f4x2_done_valid", 64'(px_valid), 64'd0);
    check("f4x2_done_busy", 64'(busy), 64'd1);
    @(posedge clk); @(negedge clk);
    check("f4x2_count", 64'(frame_count), 64'd1);
    check("f4x2_load_valid", 64'(px_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check("f4x2_restart", 64'({px_valid, px_x, px_y}), 64'({1'b1, 13'd0, 13'd0}));
    check("f4x2_act_dist", 64'(act_distance), 64'd1008);
    enable = 1'b0;
    wait_idle("f4x2_idle", 60);
    check("f4x2_count2", 64'(frame_count), 64'd2);

    // 3x3 with random backpressure
    do_cfg(3, 3);
    push_frame(3, 3);
    pulse_enable();
    for (int i = 0; i < 400; i++) begin
      px_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) break;
    end
    px_ready = 1'b1;
    wait_idle("f3x3_idle", 20);
    check("f3x3_count", 64'(frame_count), 64'd3);

    // 8x8 with a 2x2 update arriving mid-frame
    do_cfg(8, 8);
    push_frame(8, 8);
    pulse_enable();
    wait_at("f8_at32", 3, 2, 100);
    cfg_width = 13'd2; cfg_height = 13'd2; cfg_update = 1'b1; enable = 1'b1;
    @(posedge clk); #1 cfg_update = 1'b0;
    push_frame(2, 2);
    repeat (3) @(posedge clk); #1;
    check("f8_act_hold", 64'(act_width), 64'd8);
    wait_at("f8_eof", 7, 7, 100);
    check("f8_act_hold_end", 64'(act_width), 64'd8);
    repeat (3) @(posedge clk); @(negedge clk);
    check("f2_act_width", 64'({act_width, act_height}), 64'({13'd2, 13'd2}));
    enable = 1'b0;
    wait_idle("f2_idle", 40);
    check("f2_count", 64'(frame_count), 64'd5);

    // 1x1 single pixel, single-cycle enable; first-pixel latency
    do_cfg(1, 1);
    push_frame(1, 1);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    check("f1_lat_load", 64'(px_valid), 64'd0);
    @(posedge clk); #1;
    check("f1_lat_valid", 64'({px_valid, px_sof, px_eol, px_eof}), 64'hF);
    wait_idle("f1_idle", 20);
    check("f1_count", 64'(frame_count), 64'd6);
    check("f1_busy", 64'(busy), 64'd0);

    // 4x4 with asynchronous reset at pixel (2,1), then restart
    do_cfg(4, 4);
    push_frame(4, 4);
    for (int i = 0; i < 6; i++) void'(sb.pop_back());
    for (int i = 0; i < 4; i++) void'(sb.pop_back());
    pulse_enable();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (px_valid && px_x == 13'd2 && px_y == 13'd1) break;
    end
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(px_valid), 64'd0);
    check("arst_count", 64'(frame_count), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_act", 64'(act_width), 64'd0);
    check("arst_sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    do_cfg(4, 4);
    push_frame(4, 4);
    pulse_enable();
    wait_idle("f4x4_idle", 60);
    check("f4x4_count", 64'(frame_count), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
